// File: rtl/mano_sequencer.sv
// mano_sequencer
//   Control sequencer for the Mano-machine datapath. It steps the timing
//   sequence counter through T0..T6 and decodes the instruction captured from
//   the datapath IR. From those it drives the micro-operation word that the
//   datapath executes on each rising edge. It also tracks halt state and
//   counts retired instructions.
//
// Parameters
//   CW_W   control word width (only 17 is supported)
//   CNT_W  width of the retired-instruction counter
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   start        launches fetch when sampled in IDLE or HALT
//   ir           datapath IR: [15] I, [14:12] opcode, [11:0] address/reg bits
//   ac_zero      datapath AC == 0
//   ac_neg       datapath AC sign bit
//   e_flag       datapath E flip-flop
//   dr_zero      datapath DR == 0 (post-increment value, used in ISZ T6)
//   control_mem  micro-operation word for the current T state
//   opcode       opcode latched from the current instruction
//   sc           current T index (0 in IDLE and HALT)
//   busy         1 in any T state
//   halted       1 in HALT
//   instr_count  retired instructions, wrapping
module mano_sequencer #(
  parameter int CW_W  = 17,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      ir,
  input  logic             ac_zero,
  input  logic             ac_neg,
  input  logic             e_flag,
  input  logic             dr_zero,
  output logic [CW_W-1:0]  control_mem,
  output logic [2:0]       opcode,
  output logic [2:0]       sc,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  // Control word bit positions.
  localparam int B_AR_PC   = 16;
  localparam int B_IR_M    = 15;
  localparam int B_PC_INC  = 14;
  localparam int B_AR_IR   = 13;
  localparam int B_AR_M    = 12;
  localparam int B_DR_M    = 11;
  localparam int B_AC_AND  = 10;
  localparam int B_AC_ADD  = 9;
  localparam int B_AC_DR   = 8;
  localparam int B_M_AC    = 7;
  localparam int B_M_PC    = 6;
  localparam int B_AR_INC  = 5;
  localparam int B_PC_AR   = 4;
  localparam int B_DR_INC  = 3;
  localparam int B_M_DR    = 2;
  localparam int B_REG_OP  = 1;
  localparam int B_HALT    = 0;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_HALT = 4'd1,
    S_T0   = 4'd2,
    S_T1   = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_T6   = 4'd8
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       instr_end;
  logic       i_bit;
  // Only IR bits [4:0] are ever consulted by the sequencer (skip selects and
  // HLT); the remaining register-reference bits are decoded by the datapath.
  logic [4:0] reg_bits;
  logic [2:0] sc_next;
  logic       busy_next;
  logic       skip;
  logic       unused_ir_bits;

  assign unused_ir_bits = ^ir[11:5];

  // Register-reference skip: any enabled condition advances PC once more.
  assign skip = (reg_bits[4] & ~ac_neg & ~ac_zero) |
                (reg_bits[3] &  ac_neg) |
                (reg_bits[2] &  ac_zero) |
                (reg_bits[1] & ~e_flag);

  // Next-state decode; instr_end flags the last T state of an instruction so
  // the retired counter advances exactly once per completed instruction.
  always_comb begin
    state_next = state;
    instr_end  = 1'b0;
    case (state)
      S_IDLE, S_HALT: if (start) state_next = S_T0;
      S_T0: state_next = S_T1;
      S_T1: state_next = S_T2;
      S_T2: state_next = S_T3;
      S_T3: begin
        if (opcode == OP_REG) begin
          instr_end  = 1'b1;
          state_next = (!i_bit && reg_bits[0]) ? S_HALT : S_T0;
        end else begin
          state_next = S_T4;
        end
      end
      S_T4: begin
        if (opcode == OP_STA || opcode == OP_BUN) begin
          instr_end  = 1'b1;
          state_next = S_T0;
        end else begin
          state_next = S_T5;
        end
      end
      S_T5: begin
        if (opcode == OP_ISZ) begin
          state_next = S_T6;
        end else begin
          instr_end  = 1'b1;
          state_next = S_T0;
        end
      end
      S_T6: begin
        instr_end  = 1'b1;
        state_next = S_T0;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // sc/busy are registered from the next state so they line up with state.
  always_comb begin
    sc_next   = 3'd0;
    busy_next = 1'b1;
    case (state_next)
      S_T0: sc_next = 3'd0;
      S_T1: sc_next = 3'd1;
      S_T2: sc_next = 3'd2;
      S_T3: sc_next = 3'd3;
      S_T4: sc_next = 3'd4;
      S_T5: sc_next = 3'd5;
      S_T6: sc_next = 3'd6;
      default: busy_next = 1'b0;
    endcase
  end

  // State register plus latched instruction fields. The IR is captured at
  // the edge ending T2 so later IR changes cannot disturb the instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      opcode      <= 3'd0;
      i_bit       <= 1'b0;
      reg_bits    <= 5'd0;
      sc          <= 3'd0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      state  <= state_next;
      sc     <= sc_next;
      busy   <= busy_next;
      halted <= (state_next == S_HALT);
      if (state == S_T2) begin
        i_bit    <= ir[15];
        opcode   <= ir[14:12];
        reg_bits <= ir[4:0];
      end
      if (instr_end) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Micro-operation word: combinational decode of state, latched fields and
  // the live status flags. IDLE and HALT produce an all-zero NOP.
  always_comb begin
    control_mem = '0;
    case (state)
      S_T0: control_mem[B_AR_PC] = 1'b1;
      S_T1: begin
        control_mem[B_IR_M]   = 1'b1;
        control_mem[B_PC_INC] = 1'b1;
      end
      S_T2: control_mem[B_AR_IR] = 1'b1;
      S_T3: begin
        if (opcode == OP_REG) begin
          if (!i_bit) begin
            control_mem[B_REG_OP] = 1'b1;
            control_mem[B_PC_INC] = skip;
            control_mem[B_HALT]   = reg_bits[0];
          end
        end else begin
          control_mem[B_AR_M] = i_bit;
        end
      end
      S_T4: begin
        case (opcode)
          OP_AND, OP_ADD, OP_LDA, OP_ISZ: control_mem[B_DR_M] = 1'b1;
          OP_STA: control_mem[B_M_AC] = 1'b1;
          OP_BUN: control_mem[B_PC_AR] = 1'b1;
          OP_BSA: begin
            control_mem[B_M_PC]   = 1'b1;
            control_mem[B_AR_INC] = 1'b1;
          end
          default: control_mem = '0;
        endcase
      end
      S_T5: begin
        case (opcode)
          OP_AND: control_mem[B_AC_AND] = 1'b1;
          OP_ADD: control_mem[B_AC_ADD] = 1'b1;
          OP_LDA: control_mem[B_AC_DR]  = 1'b1;
          OP_BSA: control_mem[B_PC_AR]  = 1'b1;
          OP_ISZ: control_mem[B_DR_INC] = 1'b1;
          default: control_mem = '0;
        endcase
      end
      S_T6: begin
        control_mem[B_M_DR]   = 1'b1;
        control_mem[B_PC_INC] = dr_zero;
      end
      default: control_mem = '0;
    endcase
  end

endmodule
